// File: rtl/kinase_assay_sequencer.sv
// kinase_assay_sequencer
//   Runs one kinase assay: three reagent loads, a pumped mix, incubation and
//   a flush out of the selected outlet, then parks in DONE until restarted.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   0     | IDLE      waiting for start, all valves closed
//   1     | LOAD_A    reagent A valves open for LOAD_CYC cycles
//   2     | LOAD_B    reagent B valves open for LOAD_CYC cycles
//   3     | LOAD_C    reagent C valves open for LOAD_CYC cycles
//   4     | MIX       mixer pump rotates MIX_ROT times through 6 phases
//   5     | INCUBATE  hold for INC_CYC cycles
//   6     | FLUSH     flush pump + outlet valve for FLUSH_CYC cycles
//   7     | DONE      run finished, waiting for the next start
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   start, abort      run request / abort-and-flush request
//   out_sel[1:0]      outlet number, captured when a run starts
//   pad_ctrl_a[12:0]  reagent/mix/incubate/flush valves (1 = open)
//   pad_ctrl_s[3:0]   one-hot outlet valve, only driven during FLUSH
//   pad_pump_a[2:0]   mixer peristaltic pump valves, only in MIX
//   pad_pump_b[1:0]   flush pump valves, only in FLUSH
//   busy, done        run in progress / run complete
//   aborted           sticky: the last run was aborted
//   state[2:0]        current state encoding
module kinase_assay_sequencer #(
    parameter int LOAD_CYC  = 16,
    parameter int STEP_CYC  = 4,
    parameter int MIX_ROT   = 8,
    parameter int INC_CYC   = 64,
    parameter int FLUSH_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  out_sel,
    output logic [12:0] pad_ctrl_a,
    output logic [3:0]  pad_ctrl_s,
    output logic [2:0]  pad_pump_a,
    output logic [1:0]  pad_pump_b,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_A   = 3'd1,
        S_LOAD_B   = 3'd2,
        S_LOAD_C   = 3'd3,
        S_MIX      = 3'd4,
        S_INCUBATE = 3'd5,
        S_FLUSH    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam logic [15:0] LOAD_LD  = 16'(LOAD_CYC - 1);
    localparam logic [15:0] STEP_LD  = 16'(STEP_CYC - 1);
    localparam logic [15:0] ROT_LD   = 16'(MIX_ROT - 1);
    localparam logic [15:0] INC_LD   = 16'(INC_CYC - 1);
    localparam logic [15:0] FLUSH_LD = 16'(FLUSH_CYC - 1);

    state_t      cur_state, nxt_state;
    logic [15:0] cnt, nxt_cnt;          // state duration; in MIX it times one pump phase
    logic [15:0] rot_cnt, nxt_rot;      // MIX rotations still to run after this one
    logic [15:0] step_cnt, nxt_step;    // flush pump phase timer
    logic [2:0]  mix_ph, nxt_mix_ph;
    logic        flush_ph, nxt_flush_ph;
    logic [1:0]  sel_q, nxt_sel;
    logic        nxt_aborted;

    function automatic logic [12:0] ctrl_a_of(input state_t s);
        case (s)
            S_LOAD_A:   return 13'h0003;
            S_LOAD_B:   return 13'h000C;
            S_LOAD_C:   return 13'h0030;
            S_MIX:      return 13'h01C0;
            S_INCUBATE: return 13'h0E00;
            S_FLUSH:    return 13'h1000;
            default:    return 13'h0000;
        endcase
    endfunction

    function automatic logic [2:0] pump_a_of(input logic [2:0] ph);
        case (ph)
            3'd0:    return 3'b100;
            3'd1:    return 3'b110;
            3'd2:    return 3'b010;
            3'd3:    return 3'b011;
            3'd4:    return 3'b001;
            3'd5:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    always_comb begin
        nxt_state    = cur_state;
        nxt_cnt      = cnt;
        nxt_rot      = rot_cnt;
        nxt_step     = step_cnt;
        nxt_mix_ph   = mix_ph;
        nxt_flush_ph = flush_ph;
        nxt_sel      = sel_q;
        nxt_aborted  = aborted;

        case (cur_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    nxt_state   = S_LOAD_A;
                    nxt_sel     = out_sel;
                    nxt_aborted = 1'b0;
                end
            end
            S_LOAD_A:   if (cnt == 16'd0) nxt_state = S_LOAD_B;
            S_LOAD_B:   if (cnt == 16'd0) nxt_state = S_LOAD_C;
            S_LOAD_C:   if (cnt == 16'd0) nxt_state = S_MIX;
            S_MIX:      if (cnt == 16'd0 && mix_ph == 3'd5 && rot_cnt == 16'd0)
                            nxt_state = S_INCUBATE;
            S_INCUBATE: if (cnt == 16'd0) nxt_state = S_FLUSH;
            S_FLUSH:    if (cnt == 16'd0) nxt_state = S_DONE;
            default:    nxt_state = S_IDLE;
        endcase

        // Abort overrides any normal advance and always gets a full flush.
        if (abort && (cur_state inside {S_LOAD_A, S_LOAD_B, S_LOAD_C, S_MIX, S_INCUBATE})) begin
            nxt_state   = S_FLUSH;
            nxt_aborted = 1'b1;
        end

        if (nxt_state != cur_state) begin
            case (nxt_state)
                S_LOAD_A, S_LOAD_B, S_LOAD_C: nxt_cnt = LOAD_LD;
                S_MIX:                        nxt_cnt = STEP_LD;
                S_INCUBATE:                   nxt_cnt = INC_LD;
                S_FLUSH:                      nxt_cnt = FLUSH_LD;
                default:                      nxt_cnt = 16'd0;
            endcase
            nxt_rot      = (nxt_state == S_MIX)   ? ROT_LD  : 16'd0;
            nxt_step     = (nxt_state == S_FLUSH) ? STEP_LD : 16'd0;
            nxt_mix_ph   = 3'd0;
            nxt_flush_ph = 1'b0;
        end else begin
            case (cur_state)
                S_MIX: begin
                    if (cnt == 16'd0) begin
                        nxt_cnt = STEP_LD;
                        if (mix_ph == 3'd5) begin
                            nxt_mix_ph = 3'd0;
                            nxt_rot    = rot_cnt - 16'd1;
                        end else begin
                            nxt_mix_ph = mix_ph + 3'd1;
                        end
                    end else begin
                        nxt_cnt = cnt - 16'd1;
                    end
                end
                S_FLUSH: begin
                    nxt_cnt = cnt - 16'd1;
                    if (step_cnt == 16'd0) begin
                        nxt_step     = STEP_LD;
                        nxt_flush_ph = ~flush_ph;
                    end else begin
                        nxt_step = step_cnt - 16'd1;
                    end
                end
                S_LOAD_A, S_LOAD_B, S_LOAD_C, S_INCUBATE: nxt_cnt = cnt - 16'd1;
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next-state values so they change on the
    // same edge that enters a state while still coming straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= S_IDLE;
            cnt        <= 16'd0;
            rot_cnt    <= 16'd0;
            step_cnt   <= 16'd0;
            mix_ph     <= 3'd0;
            flush_ph   <= 1'b0;
            sel_q      <= 2'd0;
            aborted    <= 1'b0;
            pad_ctrl_a <= 13'd0;
            pad_ctrl_s <= 4'd0;
            pad_pump_a <= 3'd0;
            pad_pump_b <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            cnt        <= nxt_cnt;
            rot_cnt    <= nxt_rot;
            step_cnt   <= nxt_step;
            mix_ph     <= nxt_mix_ph;
            flush_ph   <= nxt_flush_ph;
            sel_q      <= nxt_sel;
            aborted    <= nxt_aborted;
            pad_ctrl_a <= ctrl_a_of(nxt_state);
            pad_ctrl_s <= (nxt_state == S_FLUSH) ? (4'b0001 << nxt_sel) : 4'd0;
            pad_pump_a <= (nxt_state == S_MIX) ? pump_a_of(nxt_mix_ph) : 3'd0;
            pad_pump_b <= (nxt_state == S_FLUSH) ? (nxt_flush_ph ? 2'b10 : 2'b01) : 2'b00;
            busy       <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done       <= (nxt_state == S_DONE);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_kinase_assay_sequencer.sv
module tb_kinase_assay_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  out_sel;
    logic [12:0] pad_ctrl_a;
    logic [3:0]  pad_ctrl_s;
    logic [2:0]  pad_pump_a;
    logic [1:0]  pad_pump_b;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [2:0]  state;

    kinase_assay_sequencer #(
        .LOAD_CYC (2),
        .STEP_CYC (1),
        .MIX_ROT  (1),
        .INC_CYC  (3),
        .FLUSH_CYC(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .out_sel   (out_sel),
        .pad_ctrl_a(pad_ctrl_a),
        .pad_ctrl_s(pad_ctrl_s),
        .pad_pump_a(pad_pump_a),
        .pad_pump_b(pad_pump_b),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          mid;
        string       name;
        logic [2:0]  st;
        logic [12:0] ca;
        logic [3:0]  cs;
        logic [2:0]  pa;
        logic [1:0]  pb;
        logic        bsy;
        logic        dn;
        logic        ab;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_chk    = 0;
    int   n_fail   = 0;
    logic [1:0] sel_exp = 2'd0;

    // Hand-derived nominal run with LOAD=2, STEP=1, ROT=1, INC=3, FLUSH=2.
    logic [2:0] st_seq [18] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                                3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
                                3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7};
    logic [2:0] pa_seq [18] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101,
                                3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [1:0] pb_seq [18] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    function automatic logic [12:0] ca_of(input logic [2:0] s);
        case (s)
            3'd1:    return 13'h0003;
            3'd2:    return 13'h000C;
            3'd3:    return 13'h0030;
            3'd4:    return 13'h01C0;
            3'd5:    return 13'h0E00;
            3'd6:    return 13'h1000;
            default: return 13'h0000;
        endcase
    endfunction

    task automatic push(input int cyc, input bit mid, input string nm,
                        input logic [2:0] est, input logic [2:0] epa,
                        input logic [1:0] epb, input logic eab);
        exp_t e;
        e.cyc  = cyc;
        e.mid  = mid;
        e.name = nm;
        e.st   = est;
        e.ca   = ca_of(est);
        e.cs   = (est == 3'd6) ? (4'b0001 << sel_exp) : 4'd0;
        e.pa   = epa;
        e.pb   = epb;
        e.bsy  = (est != 3'd0) && (est != 3'd7);
        e.dn   = (est == 3'd7);
        e.ab   = eab;
        q.push_back(e);
    endtask

    // Drive inputs for the coming edge and queue what that edge must produce.
    task automatic step(input bit s, input bit a, input logic [2:0] est,
                        input logic [2:0] epa, input logic [1:0] epb,
                        input logic eab, input string nm);
        @(negedge clk);
        #1;
        start = s;
        abort = a;
        push(edge_cnt + 1, 1'b0, nm, est, epa, epb, eab);
    endtask

    task automatic run_nominal(input logic [1:0] sel, input bit poke_inc,
                               input bit with_abort, input string nm);
        out_sel = sel;
        sel_exp = sel;
        for (int k = 0; k < 18; k++) begin
            step((k == 0) || (poke_inc && k == 13), (k == 0) ? with_abort : 1'b0,
                 st_seq[k], pa_seq[k], pb_seq[k], 1'b0, nm);
            if (k == 1) out_sel = ~sel;
        end
        step(1'b0, 1'b0, 3'd7, 3'b000, 2'b00, 1'b0, {nm, "_done_hold"});
    endtask

    task automatic check(input bit mid);
        exp_t e;
        while (q.size() > 0 &&
               (q[0].cyc < edge_cnt || (q[0].cyc == edge_cnt && q[0].mid == mid))) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc < edge_cnt) begin
                n_fail++;
                $display("FAIL %s stale entry cyc=%0d now=%0d", e.name, e.cyc, edge_cnt);
            end else if (state !== e.st || pad_ctrl_a !== e.ca || pad_ctrl_s !== e.cs ||
                         pad_pump_a !== e.pa || pad_pump_b !== e.pb || busy !== e.bsy ||
                         done !== e.dn || aborted !== e.ab) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got st=%0d ca=%h cs=%b pa=%b pb=%b busy=%b done=%b ab=%b exp st=%0d ca=%h cs=%b pa=%b pb=%b busy=%b done=%b ab=%b",
                         e.name, e.cyc, state, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b,
                         busy, done, aborted, e.st, e.ca, e.cs, e.pa, e.pb, e.bsy, e.dn, e.ab);
            end
        end
    endtask

    // Monitor: edge-aligned results at +2 after the edge, mid-cycle ones at +8.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check(1'b0);
            #6;
            check(1'b1);
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        out_sel = 2'd0;

        // Reset held across edges, even with start/abort requested.
        step(1'b1, 1'b0, 3'd0, 3'b000, 2'b00, 1'b0, "reset_hold");
        step(1'b1, 1'b1, 3'd0, 3'b000, 2'b00, 1'b0, "reset_hold2");
        step(1'b0, 1'b0, 3'd0, 3'b000, 2'b00, 1'b0, "reset_release");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'd0, 3'b000, 2'b00, 1'b0, "idle");
        step(1'b0, 1'b1, 3'd0, 3'b000, 2'b00, 1'b0, "idle_abort_ignored");

        run_nominal(2'd2, 1'b0, 1'b0, "nominal_sel2");
        step(1'b0, 1'b1, 3'd7, 3'b000, 2'b00, 1'b0, "done_abort_ignored");

        // Abort on the second MIX cycle.
        out_sel = 2'd1;
        sel_exp = 2'd1;
        for (int k = 0; k < 8; k++) begin
            step(k == 0, 1'b0, st_seq[k], pa_seq[k], pb_seq[k], 1'b0, "abort_run");
        end
        step(1'b0, 1'b1, 3'd6, 3'b000, 2'b01, 1'b1, "abort_to_flush");
        step(1'b0, 1'b0, 3'd6, 3'b000, 2'b10, 1'b1, "abort_flush2");
        step(1'b0, 1'b0, 3'd7, 3'b000, 2'b00, 1'b1, "abort_done");
        step(1'b0, 1'b1, 3'd7, 3'b000, 2'b00, 1'b1, "abort_done_abort_ignored");

        // Start+abort together in DONE, plus start poked during INCUBATE.
        run_nominal(2'd3, 1'b1, 1'b1, "start_abort_done");

        // Async reset mid-LOAD_B.
        out_sel = 2'd0;
        sel_exp = 2'd0;
        step(1'b1, 1'b0, 3'd1, 3'b000, 2'b00, 1'b0, "pre_rst_load_a");
        step(1'b0, 1'b0, 3'd1, 3'b000, 2'b00, 1'b0, "pre_rst_load_a2");
        step(1'b0, 1'b0, 3'd2, 3'b000, 2'b00, 1'b0, "pre_rst_load_b");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        push(edge_cnt, 1'b1, "async_rst_mid_cycle", 3'd0, 3'b000, 2'b00, 1'b0);
        step(1'b0, 1'b0, 3'd0, 3'b000, 2'b00, 1'b0, "rst_held");
        step(1'b0, 1'b0, 3'd0, 3'b000, 2'b00, 1'b0, "rst_held2");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'd0, 3'b000, 2'b00, 1'b0, "post_rst_idle");

        run_nominal(2'd1, 1'b0, 1'b0, "post_rst_nominal");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #10;
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain %0d expectations never checked", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
